// File: rtl/j_dac_pkg.sv
// Shared defaults and helpers for the multi-channel pulse-width DAC.
// Segment extraction is written over a wide vector so any legal SW/SEGW/NSEG can use it.
package j_dac_pkg;

  localparam int DEF_NCH   = 2;
  localparam int DEF_SW    = 16;
  localparam int DEF_SEGW  = 7;
  localparam int DEF_NSEG  = 2;
  localparam int DEF_DEPTH = 4;

  localparam int DROP = DEF_SW - DEF_NSEG * DEF_SEGW;
  localparam int MAXW = 64;

  // Segment k of a sample; the top segment's MSB flips in signed mode to give offset binary.
  function automatic logic [MAXW-1:0] seg_extract(
    input logic [MAXW-1:0] sample,
    input int              drop,
    input int              segw,
    input int              nseg,
    input int              k,
    input logic            signed_mode
  );
    logic [MAXW-1:0] seg;
    seg = (sample >> (drop + k * segw)) & ({MAXW{1'b1}} >> (MAXW - segw));
    if (signed_mode && (k == nseg - 1)) begin
      seg[segw-1] = ~seg[segw-1];
    end
    return seg;
  endfunction

  function automatic bit params_ok(input int nch, input int sw, input int segw,
                                   input int nseg, input int depth);
    return (nch >= 1) && (nch <= 8) && (segw >= 1) && (nseg >= 1) &&
           (sw >= nseg * segw) && (sw <= MAXW) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/j_dac_fifo.sv
// Per-channel sample FIFO. A pop on empty is ignored; a push on full is accepted
// only when a pop frees a slot in the same cycle (no empty bypass).
module j_dac_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/j_dac_pwm.sv
// Multi-channel pulse-width audio DAC: per-channel FIFOs feed play registers on tint,
// a shared phase counter turns each play word into NSEG weighted pulse-width outputs.
module j_dac_pwm
  import j_dac_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int SW    = DEF_SW,
  parameter int SEGW  = DEF_SEGW,
  parameter int NSEG  = DEF_NSEG,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 sys_clk,
  input  logic                 resetl,
  input  logic                 tick,
  input  logic                 ts,
  input  logic                 tint,
  input  logic                 wr,
  input  logic [CHW-1:0]       wr_ch,
  input  logic [SW-1:0]        wr_data,
  input  logic                 signed_mode,
  input  logic                 mute,
  input  logic                 clr,
  output logic [NCH*NSEG-1:0]  dac_out,
  output logic [NCH-1:0]       fifo_full,
  output logic [NCH-1:0]       ovf,
  output logic [NCH-1:0]       unf,
  output logic                 busy
);
  localparam int SEG_DROP = SW - NSEG * SEGW;
  localparam logic [SEGW-1:0] PH_MAX = '1;

  if (!params_ok(NCH, SW, SEGW, NSEG, DEPTH)) begin : g_bad_params
    $error("j_dac_pwm: illegal parameter combination");
  end

  logic [SW-1:0]       play [NCH];
  logic [SW-1:0]       head [NCH];
  logic [NCH-1:0]      empty;
  logic [NCH-1:0]      push;
  logic [NCH-1:0]      drop;
  logic [SEGW-1:0]     ph;
  logic                running;
  logic [NCH*NSEG-1:0] dac_next;
  logic [MAXW-1:0]     seg_w;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    // Out-of-range wr_ch never matches any channel index, so those writes vanish.
    assign push[ch] = wr && (wr_ch == CHW'(ch));
    assign drop[ch] = push[ch] & fifo_full[ch] & ~tint;

    j_dac_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo (
      .clk   (sys_clk),
      .rst_n (resetl),
      .push  (push[ch]),
      .pop   (tint),
      .din   (wr_data),
      .dout  (head[ch]),
      .full  (fifo_full[ch]),
      .empty (empty[ch])
    );
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      for (int c = 0; c < NCH; c++) play[c] <= '0;
    end else if (tint) begin
      for (int c = 0; c < NCH; c++) begin
        if (!empty[c]) play[c] <= head[c];
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      ovf <= '0;
      unf <= '0;
    end else begin
      ovf <= (ovf & ~{NCH{clr}}) | drop;
      unf <= (unf & ~{NCH{clr}}) | (empty & {NCH{tint}});
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      ph      <= '0;
      running <= 1'b0;
    end else if (ts) begin
      ph      <= '0;
      running <= 1'b1;
    end else if (tick && running) begin
      ph <= ph + 1'b1;
      if (ph == PH_MAX) running <= 1'b0;
    end
  end

  always_comb begin
    dac_next = '0;
    seg_w    = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NSEG; k++) begin
        seg_w = seg_extract(MAXW'(play[c]), SEG_DROP, SEGW, NSEG, k, signed_mode);
        dac_next[c*NSEG+k] = running & ~mute & (ph < seg_w[SEGW-1:0]);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) dac_out <= '0;
    else         dac_out <= dac_next;
  end

  assign busy = running;

endmodule

// File: tb/tb_j_dac_pwm.sv
// Directed bench for j_dac_pwm: a table of single-sample frames with hand-computed
// pulse counts, followed by sequences for FIFO status, restart, mute and reset.
module tb_j_dac_pwm;

  logic        sys_clk = 1'b0;
  logic        resetl = 1'b0;
  logic        tick = 1'b0;
  logic        ts = 1'b0;
  logic        tint = 1'b0;
  logic        wr = 1'b0;
  logic [0:0]  wr_ch = 1'b0;
  logic [15:0] wr_data = '0;
  logic        signed_mode = 1'b0;
  logic        mute = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  dac_out;
  logic [1:0]  fifo_full;
  logic [1:0]  ovf;
  logic [1:0]  unf;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        sm;
    int          ch;
    logic [15:0] sample;
    int          exp0;
    int          exp1;
  } vec_t;

  vec_t vecs[7];

  j_dac_pwm dut (
    .sys_clk     (sys_clk),
    .resetl      (resetl),
    .tick        (tick),
    .ts          (ts),
    .tint        (tint),
    .wr          (wr),
    .wr_ch       (wr_ch),
    .wr_data     (wr_data),
    .signed_mode (signed_mode),
    .mute        (mute),
    .clr         (clr),
    .dac_out     (dac_out),
    .fifo_full   (fifo_full),
    .ovf         (ovf),
    .unf         (unf),
    .busy        (busy)
  );

  // clock / watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic write_sample(input int ch, input logic [15:0] d);
    wr      = 1'b1;
    wr_ch   = 1'(ch);
    wr_data = d;
    cyc();
    wr      = 1'b0;
  endtask

  task automatic start_frame(input logic load);
    tint = load;
    ts   = 1'b1;
    cyc();
    tint = 1'b0;
    ts   = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  task automatic pulse_tint();
    tint = 1'b1;
    cyc();
    tint = 1'b0;
  endtask

  // n ticks plus one idle cycle; counts high samples of both segments of channel ch
  task automatic run_ticks(input int n, input int ch, output int c0, output int c1,
                           output logic busy_prev, output logic busy_last);
    c0 = 0;
    c1 = 0;
    busy_prev = 1'b0;
    busy_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      if (dac_out[ch*2])   c0++;
      if (dac_out[ch*2+1]) c1++;
      busy_prev = busy_last;
      busy_last = busy;
    end
    tick = 1'b0;
    cyc();
    if (dac_out[ch*2])   c0++;
    if (dac_out[ch*2+1]) c1++;
  endtask

  initial begin
    int   c0;
    int   c1;
    logic bp;
    logic bl;
    logic any_high;

    vecs[0] = '{1'b1, 0, 16'h0000, 0, 64};
    vecs[1] = '{1'b1, 1, 16'h7FFC, 127, 127};
    vecs[2] = '{1'b0, 1, 16'hFFFC, 127, 127};
    vecs[3] = '{1'b0, 0, 16'h0003, 0, 0};
    vecs[4] = '{1'b0, 0, 16'h0204, 1, 1};
    vecs[5] = '{1'b1, 1, 16'h8000, 0, 0};
    vecs[6] = '{1'b0, 1, 16'h1234, 13, 9};

    // reset
    resetl = 1'b0;
    repeat (3) cyc();
    resetl = 1'b1;
    cyc();
    check("reset dac_out", 32'(dac_out), 32'd0);
    check("reset fifo_full", 32'(fifo_full), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset unf", 32'(unf), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    // table: one sample per frame, tint and ts together
    for (int v = 0; v < 7; v++) begin
      signed_mode = vecs[v].sm;
      write_sample(vecs[v].ch, vecs[v].sample);
      start_frame(1'b1);
      run_ticks(128, vecs[v].ch, c0, c1, bp, bl);
      exp_q.push_back(32'(vecs[v].exp0));
      exp_q.push_back(32'(vecs[v].exp1));
      check($sformatf("vec%0d seg0 high ticks", v), 32'(c0), exp_q.pop_front());
      check($sformatf("vec%0d seg1 high ticks", v), 32'(c1), exp_q.pop_front());
      check($sformatf("vec%0d busy at tick 127", v), 32'(bp), 32'd1);
      check($sformatf("vec%0d busy after tick 128", v), 32'(bl), 32'd0);
    end

    // underflow keeps play[1] = 0x1234; set wins over clr
    pulse_clr();
    check("clr unf", 32'(unf), 32'd0);
    tint = 1'b1;
    clr  = 1'b1;
    cyc();
    tint = 1'b0;
    clr  = 1'b0;
    check("unf set with clr", 32'(unf), 32'b11);
    start_frame(1'b0);
    run_ticks(128, 1, c0, c1, bp, bl);
    check("held play1 seg0", 32'(c0), 32'd13);
    check("held play1 seg1", 32'(c1), 32'd9);
    pulse_clr();

    // overflow on ch0
    write_sample(0, 16'h0000);
    write_sample(0, 16'h0204);
    write_sample(0, 16'h0003);
    check("full after 3 writes", 32'(fifo_full), 32'd0);
    write_sample(0, 16'h8000);
    check("full after 4 writes", 32'(fifo_full), 32'b01);
    check("no ovf after 4 writes", 32'(ovf), 32'd0);
    write_sample(0, 16'hFFFC);
    check("ovf after 5th write", 32'(ovf), 32'b01);
    pulse_clr();
    check("ovf cleared", 32'(ovf), 32'd0);

    // push and pop together on a full FIFO
    tint = 1'b1;
    write_sample(0, 16'h1234);
    tint = 1'b0;
    check("full after push+pop", 32'(fifo_full[0]), 32'd1);
    check("no ovf on push+pop", 32'(ovf), 32'd0);
    repeat (4) pulse_tint();
    check("drained not full", 32'(fifo_full), 32'd0);
    pulse_clr();
    pulse_tint();
    check("unf0 after drain", 32'(unf[0]), 32'd1);
    start_frame(1'b0);
    run_ticks(128, 0, c0, c1, bp, bl);
    check("last stored sample seg0", 32'(c0), 32'd13);
    check("last stored sample seg1", 32'(c1), 32'd9);

    // ts mid-frame at ph = 50 (with tick) restarts the frame
    start_frame(1'b0);
    run_ticks(50, 0, c0, c1, bp, bl);
    check("partial frame seg0", 32'(c0), 32'd13);
    check("partial frame seg1", 32'(c1), 32'd9);
    ts   = 1'b1;
    tick = 1'b1;
    cyc();
    ts   = 1'b0;
    tick = 1'b0;
    check("busy after restart", 32'(busy), 32'd1);
    run_ticks(128, 0, c0, c1, bp, bl);
    check("restart seg0", 32'(c0), 32'd13);
    check("restart seg1", 32'(c1), 32'd9);
    check("restart ends", 32'(bl), 32'd0);

    // mute: phase still runs out
    start_frame(1'b0);
    mute = 1'b1;
    run_ticks(128, 0, c0, c1, bp, bl);
    mute = 1'b0;
    check("mute seg0", 32'(c0), 32'd0);
    check("mute seg1", 32'(c1), 32'd0);
    check("mute busy at tick 127", 32'(bp), 32'd1);
    check("mute busy after tick 128", 32'(bl), 32'd0);

    // async reset mid-frame
    write_sample(0, 16'hFFFC);
    write_sample(0, 16'h0204);
    write_sample(1, 16'h0204);
    start_frame(1'b1);
    tick = 1'b1;
    repeat (5) cyc();
    check("pre-reset dac_out ch0", 32'(dac_out[1:0]), 32'b11);
    resetl = 1'b0;
    #1;
    check("reset dac_out immediate", 32'(dac_out), 32'd0);
    check("reset busy immediate", 32'(busy), 32'd0);
    check("reset fifo_full immediate", 32'(fifo_full), 32'd0);
    cyc();
    resetl = 1'b1;
    any_high = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (dac_out != 4'd0 || busy) any_high = 1'b1;
    end
    tick = 1'b0;
    check("idle after reset", 32'(any_high), 32'd0);
    pulse_tint();
    check("fifos empty after reset", 32'(unf), 32'b11);
    start_frame(1'b0);
    run_ticks(128, 0, c0, c1, bp, bl);
    check("play cleared seg0", 32'(c0), 32'd0);
    check("play cleared seg1", 32'(c1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/j_dac_pwm.md
# j_dac_pwm

Parametrised multi-channel pulse-width audio DAC, successor to the fixed two-channel, two-segment DAC. The DSP writes samples into per-channel FIFOs. On each frame strobe one sample per channel moves into a play register. A shared phase counter then drives NSEG pulse-width outputs per channel, which the board sums through a weighted resistor network. New over the fixed block: per-channel FIFO buffering, configurable channels/segments/widths, signed/unsigned mode, mute, and overflow/underflow status.

## Interface
- NCH, 2, channel count (1..8)
- SW, 16, sample width
- SEGW, 7, bits per pulse segment
- NSEG, 2, segments per channel; SW >= NSEG*SEGW
- DEPTH, 4, FIFO entries per channel (power of 2, >= 2)
- sys_clk  in  1  single clock, all state on rising edge
- resetl  in  1  asynchronous active-low reset
- tick  in  1  phase-advance enable (one pulse per DAC step)
- ts  in  1  frame sync: restart pulse phase
- tint  in  1  frame load: pop one sample per channel into play registers
- wr  in  1  sample write strobe
- wr_ch  in  $clog2(NCH) (min 1)  target channel
- wr_data  in  SW  sample
- signed_mode  in  1  1 = two's-complement samples (top segment MSB inverted)
- mute  in  1  force all outputs low
- clr  in  1  clear sticky status
- dac_out  out  NCH*NSEG  pulse outputs; bit ch*NSEG+k is segment k of channel ch
- fifo_full  out  NCH  per-channel FIFO full
- ovf  out  NCH  sticky: write dropped on full
- unf  out  NCH  sticky: tint found FIFO empty
- busy  out  1  phase counter running

## Operation
- Write path: wr with FIFO[wr_ch] not full pushes wr_data. wr with FIFO[wr_ch] full drops the data and sets ovf[wr_ch]. wr_ch >= NCH is ignored.
- Load path, on tint, for each channel:
  - Non-empty FIFO: pop into play[ch].
  - Empty FIFO: play[ch] holds its old value and unf[ch] is set.
- Segment extraction: the SW-NSEG*SEGW LSBs are discarded. Segment k = play[ch][(SW-NSEG*SEGW)+k*SEGW +: SEGW]. When signed_mode = 1, the MSB of segment NSEG-1 is inverted, giving offset binary.
- Phase counter ph is SEGW bits.
  - On ts: ph <= 0, running <= 1.
  - On tick while running: ph <= ph+1. A tick at ph = 2^SEGW-1 clears running; ph wraps to 0.
  - tick while idle: no change.
- Pulse: dac_out bit = running & ~mute & (ph < seg). High time is seg ticks: seg = 0 never goes high; seg = 2^SEGW-1 is high for all but the last tick.
- Status: clr zeroes ovf and unf. A set event and clr in the same cycle leaves the bit set.

## Timing
- Reset values: ph = 0, running = 0, play = 0, FIFOs empty, dac_out = 0, fifo_full = 0, ovf = 0, unf = 0, busy = 0.
- wr at cycle t: entry visible to a tint at t+1. fifo_full asserts at t+1.
- tint at t: play valid from t+1.
- ts at t: running = 1 and ph = 0 at t+1.
- dac_out is registered: it reflects running/ph/play/mute from the previous cycle. The first high output follows ts by 2 cycles.
- Simultaneous events:
  - Push and pop on the same channel in one cycle: both happen, occupancy unchanged. A full FIFO accepts the write; an empty FIFO does not bypass, so unf is set and the write is stored.
  - ts and tick together: ts wins, ph = 0.
  - ts during running: restart.
  - tint and ts together: both take effect; the new frame uses the new play value.
- Async reset mid-frame: all outputs low immediately. After release, operation resumes only on the next ts.

## Structure
- j_dac_pkg:
  - default parameters
  - localparam DROP = SW-NSEG*SEGW
  - function seg_extract(sample, k, signed_mode)
  - parameter legality checks (SW >= NSEG*SEGW, DEPTH power of 2)
- Sub-module j_dac_fifo (SW x DEPTH, push/pop/full/empty, async active-low reset), instantiated NCH times via generate.
- Phase counter, play registers, comparators and status live in the top level.

## Test plan
- Defaults, signed_mode = 1. Write ch0 = 0x0000, tint, ts, then 128 ticks -> dac_out[1] high exactly 64 ticks, dac_out[0] never high, busy drops after tick 128.
- Write ch1 = 0x7FFC (signed) and ch1 = 0xFFFC (unsigned), each followed by tint/ts/128 ticks -> dac_out[3] and dac_out[2] each high 127 ticks.
- Write 5 samples to ch0 with DEPTH = 4 -> fifo_full[0] = 1 after the 4th write, ovf[0] = 1, 5th sample never plays. clr -> ovf[0] = 0.
- tint with ch1 empty and play[1] = 0x1234 -> play[1] unchanged, unf[1] = 1. Push/pop in the same cycle on a full FIFO -> stays full, no ovf.
- ts asserted mid-frame at ph = 50 -> ph = 0 next cycle, pulses restart. mute = 1 -> dac_out = 0 while ph still advances.
- resetl low mid-frame with dac_out nonzero -> all outputs 0 immediately, FIFOs empty. After release, no pulses until ts.
